friscv_mem_arbiter: RTL

- Two-requester arbiter sharing one en/wr/addr/wdata/strb/rdata/ready memory-style slave port.
- Typical use: load/store unit (mst0) and debug/DMA requester (mst1) both reaching the data memory router's master side.
- Registered grant state machine with round-robin fairness; one request owns the slave until its ready handshake completes.

---
 rtl/friscv_mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/friscv_mem_arbiter.sv
// friscv_mem_arbiter: round-robin arbiter for two memory-style masters sharing one slave port.
// Optional grant watchdog enabled by defining FRISCV_MEM_ARB_TIMEOUT_EN.
module friscv_mem_arbiter #(
  parameter int ADDRW   = 16,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               aclk,
  input  logic               srst,
  input  logic               mst0_en,
  input  logic               mst0_wr,
  input  logic [ADDRW-1:0]   mst0_addr,
  input  logic [XLEN-1:0]    mst0_wdata,
  input  logic [XLEN/8-1:0]  mst0_strb,
  output logic [XLEN-1:0]    mst0_rdata,
  output logic               mst0_ready,
  input  logic               mst1_en,
  input  logic               mst1_wr,
  input  logic [ADDRW-1:0]   mst1_addr,
  input  logic [XLEN-1:0]    mst1_wdata,
  input  logic [XLEN/8-1:0]  mst1_strb,
  output logic [XLEN-1:0]    mst1_rdata,
  output logic               mst1_ready,
  output logic               slv_en,
  output logic               slv_wr,
  output logic [ADDRW-1:0]   slv_addr,
  output logic [XLEN-1:0]    slv_wdata,
  output logic [XLEN/8-1:0]  slv_strb,
  input  logic [XLEN-1:0]    slv_rdata,
  input  logic               slv_ready,
  output logic               timeout_err
);

  localparam int STRBW = XLEN / 8;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("friscv_mem_arbiter: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               gnt0;
  logic               gnt1;
  logic               sel_en;
  logic               sel_wr;
  logic [ADDRW-1:0]   sel_addr;
  logic [XLEN-1:0]    sel_wdata;
  logic [STRBW-1:0]   sel_strb;
  logic               abort;
  logic               done;

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);

  // Request of whichever master currently owns the slave; all zero while idle.
  always_comb begin
    sel_en    = 1'b0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_strb  = '0;
    if (gnt0) begin
      sel_en    = mst0_en;
      sel_wr    = mst0_wr;
      sel_addr  = mst0_addr;
      sel_wdata = mst0_wdata;
      sel_strb  = mst0_strb;
    end else if (gnt1) begin
      sel_en    = mst1_en;
      sel_wr    = mst1_wr;
      sel_addr  = mst1_addr;
      sel_wdata = mst1_wdata;
      sel_strb  = mst1_strb;
    end
  end

`ifdef FRISCV_MEM_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] LAST_WAIT = CNTW'(TIMEOUT - 1);

  logic [CNTW-1:0] wait_cnt;

  // Counts stalled grant cycles; the abort fires on the TIMEOUT-th one.
  assign abort = sel_en & ~slv_ready & (wait_cnt == LAST_WAIT);

  always_ff @(posedge aclk) begin
    if (srst || !sel_en || done) begin
      wait_cnt <= '0;
    end else if (!slv_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_err = abort & ~srst;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign done = sel_en & (slv_ready | abort);

  assign slv_en    = sel_en & ~abort;
  assign slv_wr    = sel_wr;
  assign slv_addr  = sel_addr;
  assign slv_wdata = sel_wdata;
  assign slv_strb  = sel_strb;

  // A reset arriving mid-transfer must not hand a completion back to the master.
  assign mst0_ready = gnt0 & ~srst & (slv_ready | abort);
  assign mst1_ready = gnt1 & ~srst & (slv_ready | abort);
  assign mst0_rdata = (gnt0 && !abort) ? slv_rdata : '0;
  assign mst1_rdata = (gnt1 && !abort) ? slv_rdata : '0;

  // On a tie the master that was not served last wins.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (mst0_en && (!mst1_en || last_grant)) begin
            state <= GRANT0;
          end else if (mst1_en) begin
            state <= GRANT1;
          end
        end
        GRANT0: begin
          if (!mst0_en) begin
            state <= IDLE;
          end else if (done) begin
            last_grant <= 1'b0;
            state      <= mst1_en ? GRANT1 : IDLE;
          end
        end
        GRANT1: begin
          if (!mst1_en) begin
            state <= IDLE;
          end else if (done) begin
            last_grant <= 1'b1;
            state      <= mst0_en ? GRANT0 : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
